n64_bus_arbiter: RTL and testbench

Two-master, one-slave bus arbiter directly downstream of the N64 PI bridge: it accepts PI bus requests (request/write/bank/address/data with busy/ack handshake) and CPU-side requests, serialises them onto the single memory bus, and returns read data and completion acks to the owning master. It allows one outstanding transaction. Bank 0 (unmapped) requests are completed internally without touching memory.

---
 rtl/n64_bus_pkg.sv | 31 +++
 rtl/n64_arbiter_select.sv | 28 ++
 rtl/n64_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_n64_bus_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_bus_pkg.sv
// Shared types and constants for the N64 PI/CPU memory bus arbiter.
// Bank 0 is unmapped; reads from it return all ones.
package n64_bus_pkg;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int BANK_W = 4;

    localparam logic [BANK_W-1:0] BANK_INVALID = 4'd0;
    localparam logic [BANK_W-1:0] BANK_SDRAM   = 4'd1;
    localparam logic [BANK_W-1:0] BANK_CART    = 4'd2;

    localparam logic [DATA_W-1:0] UNMAPPED_READ = 32'hFFFF_FFFF;

    typedef enum logic {
        MASTER_PI  = 1'b0,
        MASTER_CPU = 1'b1
    } master_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_LOCAL_ACK = 2'd3
    } arb_state_t;

    function automatic logic is_unmapped(input logic [BANK_W-1:0] bank);
        return bank == BANK_INVALID;
    endfunction

endpackage

// File: rtl/n64_arbiter_select.sv
// Combinational winner selection between the PI and CPU masters.
// With N64_ARB_ROUND_ROBIN_EN the master not served last wins a tie; otherwise PI wins.
module n64_arbiter_select
    import n64_bus_pkg::*;
(
    input  logic    pi_request,
    input  logic    cpu_request,
`ifdef N64_ARB_ROUND_ROBIN_EN
    input  master_t last_served,
`endif
    output logic    grant_valid,
    output master_t winner
);

    always_comb begin
        grant_valid = pi_request | cpu_request;
        winner      = MASTER_PI;
        if (cpu_request && !pi_request) begin
            winner = MASTER_CPU;
        end
`ifdef N64_ARB_ROUND_ROBIN_EN
        else if (cpu_request && pi_request && last_served == MASTER_PI) begin
            winner = MASTER_CPU;
        end
`endif
    end

endmodule

// File: rtl/n64_bus_arbiter.sv
// Two-master (PI, CPU) to one memory bus arbiter, one outstanding transaction.
// Optional N64_ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of PI priority.
module n64_bus_arbiter
    import n64_bus_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,

    input  logic              i_pi_request,
    input  logic              i_pi_write,
    input  logic [BANK_W-1:0] i_pi_bank,
    input  logic [ADDR_W-1:0] i_pi_address,
    input  logic [DATA_W-1:0] i_pi_data,
    output logic              o_pi_busy,
    output logic              o_pi_ack,
    output logic [DATA_W-1:0] o_pi_data,

    input  logic              i_cpu_request,
    input  logic              i_cpu_write,
    input  logic [BANK_W-1:0] i_cpu_bank,
    input  logic [ADDR_W-1:0] i_cpu_address,
    input  logic [DATA_W-1:0] i_cpu_data,
    output logic              o_cpu_busy,
    output logic              o_cpu_ack,
    output logic [DATA_W-1:0] o_cpu_data,

    output logic              o_mem_request,
    output logic              o_mem_write,
    output logic [BANK_W-1:0] o_mem_bank,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic              i_mem_busy,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_data
);

    arb_state_t        state_reg, state_next;
    master_t           owner_reg;
    logic              mem_write_reg;
    logic [BANK_W-1:0] mem_bank_reg;
    logic [ADDR_W-1:0] mem_address_reg;
    logic [DATA_W-1:0] mem_data_reg;

    logic              grant_valid;
    master_t           winner;
    logic              accept;
    logic              sel_write;
    logic [BANK_W-1:0] sel_bank;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_data;
    logic              done;

`ifdef N64_ARB_ROUND_ROBIN_EN
    master_t last_reg;
`endif

    n64_arbiter_select u_select (
        .pi_request  (i_pi_request),
        .cpu_request (i_cpu_request),
`ifdef N64_ARB_ROUND_ROBIN_EN
        .last_served (last_reg),
`endif
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    assign accept      = (state_reg == ST_IDLE) && grant_valid;
    assign sel_write   = (winner == MASTER_CPU) ? i_cpu_write   : i_pi_write;
    assign sel_bank    = (winner == MASTER_CPU) ? i_cpu_bank    : i_pi_bank;
    assign sel_address = (winner == MASTER_CPU) ? i_cpu_address : i_pi_address;
    assign sel_data    = (winner == MASTER_CPU) ? i_cpu_data    : i_pi_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg       <= ST_IDLE;
            owner_reg       <= MASTER_PI;
            mem_write_reg   <= 1'b0;
            mem_bank_reg    <= '0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
`ifdef N64_ARB_ROUND_ROBIN_EN
            last_reg        <= MASTER_CPU;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg       <= winner;
                mem_write_reg   <= sel_write;
                mem_bank_reg    <= sel_bank;
                mem_address_reg <= sel_address;
                mem_data_reg    <= sel_data;
`ifdef N64_ARB_ROUND_ROBIN_EN
                last_reg        <= winner;
`endif
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        o_mem_request = 1'b0;
        done          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = is_unmapped(sel_bank) ? ST_LOCAL_ACK : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mem_request = 1'b1;
                if (!i_mem_busy) begin
                    state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (i_mem_ack) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_LOCAL_ACK: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Acks are suppressed while reset is held so an in-flight memory ack never leaks out.
    assign o_pi_ack  = done && !i_reset && (owner_reg == MASTER_PI);
    assign o_cpu_ack = done && !i_reset && (owner_reg == MASTER_CPU);

    assign o_pi_data  = (state_reg == ST_LOCAL_ACK && owner_reg == MASTER_PI)  ? UNMAPPED_READ : i_mem_data;
    assign o_cpu_data = (state_reg == ST_LOCAL_ACK && owner_reg == MASTER_CPU) ? UNMAPPED_READ : i_mem_data;

    assign o_pi_busy  = !(accept && winner == MASTER_PI);
    assign o_cpu_busy = !(accept && winner == MASTER_CPU);

    assign o_mem_write   = mem_write_reg;
    assign o_mem_bank    = mem_bank_reg;
    assign o_mem_address = mem_address_reg;
    assign o_mem_data    = mem_data_reg;

endmodule

// File: tb/tb_n64_bus_arbiter.sv
// Directed self-checking bench for n64_bus_arbiter; round-robin expectations under N64_ARB_ROUND_ROBIN_EN.
module tb_n64_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_pi_request = 1'b0, i_pi_write = 1'b0;
    logic [3:0]  i_pi_bank = '0;
    logic [25:0] i_pi_address = '0;
    logic [31:0] i_pi_data = '0;
    logic        o_pi_busy, o_pi_ack;
    logic [31:0] o_pi_data;
    logic        i_cpu_request = 1'b0, i_cpu_write = 1'b0;
    logic [3:0]  i_cpu_bank = '0;
    logic [25:0] i_cpu_address = '0;
    logic [31:0] i_cpu_data = '0;
    logic        o_cpu_busy, o_cpu_ack;
    logic [31:0] o_cpu_data;
    logic        o_mem_request, o_mem_write;
    logic [3:0]  o_mem_bank;
    logic [25:0] o_mem_address;
    logic [31:0] o_mem_data;
    logic        i_mem_busy = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_mem_data = '0;

    int total = 0;
    int bad = 0;

    n64_bus_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_pi_request(i_pi_request), .i_pi_write(i_pi_write), .i_pi_bank(i_pi_bank),
        .i_pi_address(i_pi_address), .i_pi_data(i_pi_data),
        .o_pi_busy(o_pi_busy), .o_pi_ack(o_pi_ack), .o_pi_data(o_pi_data),
        .i_cpu_request(i_cpu_request), .i_cpu_write(i_cpu_write), .i_cpu_bank(i_cpu_bank),
        .i_cpu_address(i_cpu_address), .i_cpu_data(i_cpu_data),
        .o_cpu_busy(o_cpu_busy), .o_cpu_ack(o_cpu_ack), .o_cpu_data(o_cpu_data),
        .o_mem_request(o_mem_request), .o_mem_write(o_mem_write), .o_mem_bank(o_mem_bank),
        .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
        .i_mem_busy(i_mem_busy), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        step();
        step();
        i_reset = 1'b0;
        #1;
        total++; if (o_mem_request !== 1'b0) begin bad++; $display("FAIL reset_mem_request got %b need 0", o_mem_request); end
        total++; if (o_mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got %b need 0", o_mem_write); end
        total++; if ({o_mem_bank, o_mem_address, o_mem_data} !== 62'd0) begin bad++; $display("FAIL reset_mem_fields got %h/%h/%h need 0", o_mem_bank, o_mem_address, o_mem_data); end
        total++; if ({o_pi_ack, o_cpu_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got %b need 00", {o_pi_ack, o_cpu_ack}); end
        total++; if ({o_pi_busy, o_cpu_busy} !== 2'b11) begin bad++; $display("FAIL reset_busy got %b need 11", {o_pi_busy, o_cpu_busy}); end
        $display("txn reset: done");
    endtask

    task automatic test_pi_read();
        int req_cnt = 0;
        int ack_cnt = 0;
        int cpu_ack_cnt = 0;
        i_pi_request = 1'b1; i_pi_write = 1'b0; i_pi_bank = 4'd1; i_pi_address = 26'h0000100;
        i_mem_busy = 1'b1;
        #1;
        total++; if (o_pi_busy !== 1'b0) begin bad++; $display("FAIL pi_read_accept_busy got %b need 0", o_pi_busy); end
        total++; if (o_mem_request !== 1'b0) begin bad++; $display("FAIL pi_read_req_at_accept got %b need 0", o_mem_request); end
        step();
        i_pi_request = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            i_mem_busy = (k <= 2);
            i_mem_ack  = (k == 6);
            i_mem_data = (k == 6) ? 32'hDEADBEEF : 32'h0;
            #1;
            if (o_mem_request === 1'b1) req_cnt++;
            if (o_cpu_ack === 1'b1) cpu_ack_cnt++;
            if (k == 1) begin
                total++;
                if ({o_mem_write, o_mem_bank, o_mem_address} !== {1'b0, 4'd1, 26'h0000100}) begin
                    bad++; $display("FAIL pi_read_fields got %b/%h/%h need 0/1/0000100", o_mem_write, o_mem_bank, o_mem_address);
                end
            end
            if (o_pi_ack === 1'b1) begin
                ack_cnt++;
                total++; if (o_pi_data !== 32'hDEADBEEF) begin bad++; $display("FAIL pi_read_data got %h need deadbeef", o_pi_data); end
                total++; if (k != 6) begin bad++; $display("FAIL pi_read_ack_cycle got %0d need 6", k); end
            end
            step();
        end
        i_mem_ack = 1'b0; i_mem_busy = 1'b0;
        total++; if (req_cnt != 3) begin bad++; $display("FAIL pi_read_req_cycles got %0d need 3", req_cnt); end
        total++; if (ack_cnt != 1) begin bad++; $display("FAIL pi_read_ack_count got %0d need 1", ack_cnt); end
        total++; if (cpu_ack_cnt != 0) begin bad++; $display("FAIL pi_read_cpu_ack got %0d need 0", cpu_ack_cnt); end
        $display("txn pi_read bank1 addr 0000100: req_cycles=%0d ack=%0d", req_cnt, ack_cnt);
    endtask

    task automatic test_simultaneous();
        i_reset = 1'b1; step(); i_reset = 1'b0;
        i_pi_request  = 1'b1; i_pi_write  = 1'b0; i_pi_bank  = 4'd1; i_pi_address  = 26'h10;
        i_cpu_request = 1'b1; i_cpu_write = 1'b0; i_cpu_bank = 4'd1; i_cpu_address = 26'h20;
`ifdef N64_ARB_ROUND_ROBIN_EN
        for (int r = 0; r < 4; r++) begin
            logic exp_pi;
            exp_pi = (r % 2 == 0);
            #1;
            total++; if ({o_pi_busy, o_cpu_busy} !== (exp_pi ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_round%0d_busy got %b need %b", r, {o_pi_busy, o_cpu_busy}, exp_pi ? 2'b01 : 2'b10); end
            step();
            #1;
            total++; if (o_mem_address !== (exp_pi ? 26'h10 : 26'h20)) begin bad++; $display("FAIL rr_round%0d_addr got %h need %h", r, o_mem_address, exp_pi ? 26'h10 : 26'h20); end
            step();
            i_mem_ack = 1'b1; i_mem_data = 32'hA0 + r;
            #1;
            total++; if ({o_pi_ack, o_cpu_ack} !== (exp_pi ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_round%0d_ack got %b need %b", r, {o_pi_ack, o_cpu_ack}, exp_pi ? 2'b10 : 2'b01); end
            step();
            i_mem_ack = 1'b0;
            $display("txn rr round %0d: winner=%s", r, exp_pi ? "PI" : "CPU");
        end
        i_pi_request = 1'b0; i_cpu_request = 1'b0;
`else
        #1;
        total++; if ({o_pi_busy, o_cpu_busy} !== 2'b01) begin bad++; $display("FAIL prio_first_busy got %b need 01", {o_pi_busy, o_cpu_busy}); end
        step();
        i_pi_request = 1'b0;
        #1;
        total++; if (o_mem_address !== 26'h10) begin bad++; $display("FAIL prio_first_addr got %h need 010", o_mem_address); end
        total++; if (o_cpu_busy !== 1'b1) begin bad++; $display("FAIL prio_cpu_wait_busy got %b need 1", o_cpu_busy); end
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0000_000A;
        #1;
        total++; if ({o_pi_ack, o_cpu_ack} !== 2'b10) begin bad++; $display("FAIL prio_first_ack got %b need 10", {o_pi_ack, o_cpu_ack}); end
        step();
        i_mem_ack = 1'b0;
        #1;
        total++; if ({o_pi_busy, o_cpu_busy} !== 2'b10) begin bad++; $display("FAIL prio_second_busy got %b need 10", {o_pi_busy, o_cpu_busy}); end
        step();
        i_cpu_request = 1'b0;
        #1;
        total++; if (o_mem_address !== 26'h20) begin bad++; $display("FAIL prio_second_addr got %h need 020", o_mem_address); end
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0000_000B;
        #1;
        total++; if ({o_pi_ack, o_cpu_ack, o_cpu_data} !== {2'b01, 32'h0000_000B}) begin bad++; $display("FAIL prio_second_ack got %b%b/%h need 01/0000000b", o_pi_ack, o_cpu_ack, o_cpu_data); end
        step();
        i_mem_ack = 1'b0;
        $display("txn simultaneous: PI then CPU");
`endif
    endtask

    task automatic test_bank0_write();
        int busy_low = 0;
        i_cpu_request = 1'b1; i_cpu_write = 1'b1; i_cpu_bank = 4'd0; i_cpu_address = 26'h44; i_cpu_data = 32'h1111_2222;
        #1;
        if (o_cpu_busy === 1'b0) busy_low++;
        step();
        i_cpu_request = 1'b0;
        #1;
        if (o_cpu_busy === 1'b0) busy_low++;
        total++; if (o_cpu_ack !== 1'b1) begin bad++; $display("FAIL bank0_ack got %b need 1", o_cpu_ack); end
        total++; if (o_cpu_data !== 32'hFFFF_FFFF) begin bad++; $display("FAIL bank0_data got %h need ffffffff", o_cpu_data); end
        total++; if (o_mem_request !== 1'b0) begin bad++; $display("FAIL bank0_mem_request got %b need 0", o_mem_request); end
        total++; if (o_pi_ack !== 1'b0) begin bad++; $display("FAIL bank0_pi_ack got %b need 0", o_pi_ack); end
        step();
        #1;
        if (o_cpu_busy === 1'b0) busy_low++;
        total++; if ({o_cpu_ack, o_mem_request} !== 2'b00) begin bad++; $display("FAIL bank0_after got %b need 00", {o_cpu_ack, o_mem_request}); end
        total++; if (busy_low != 1) begin bad++; $display("FAIL bank0_busy_cycles got %0d need 1", busy_low); end
        $display("txn cpu_write bank0: local ack");
    endtask

    task automatic test_stray_ack();
        i_mem_ack = 1'b1; i_mem_data = 32'h0BAD_0BAD;
        #1;
        total++; if ({o_pi_ack, o_cpu_ack} !== 2'b00) begin bad++; $display("FAIL stray_idle_ack got %b need 00", {o_pi_ack, o_cpu_ack}); end
        step();
        i_mem_ack = 1'b0;
        i_pi_request = 1'b1; i_pi_write = 1'b0; i_pi_bank = 4'd1; i_pi_address = 26'h40;
        #1;
        total++; if (o_pi_busy !== 1'b0) begin bad++; $display("FAIL stray_idle_state busy got %b need 0", o_pi_busy); end
        step();
        i_pi_request = 1'b0; i_mem_busy = 1'b1; i_mem_ack = 1'b1;
        #1;
        total++; if ({o_pi_ack, o_mem_request} !== 2'b01) begin bad++; $display("FAIL stray_issue got ack=%b req=%b need ack=0 req=1", o_pi_ack, o_mem_request); end
        step();
        i_mem_ack = 1'b0;
        #1;
        total++; if (o_mem_request !== 1'b1) begin bad++; $display("FAIL stray_issue_hold got %b need 1", o_mem_request); end
        i_mem_busy = 1'b0;
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0000_0077;
        #1;
        total++; if ({o_pi_ack, o_pi_data} !== {1'b1, 32'h0000_0077}) begin bad++; $display("FAIL stray_final_ack got %b/%h need 1/00000077", o_pi_ack, o_pi_data); end
        step();
        i_mem_ack = 1'b0;
        $display("txn stray ack: ignored");
    endtask

    task automatic test_reset_mid();
        i_pi_request = 1'b1; i_pi_write = 1'b1; i_pi_bank = 4'd3; i_pi_address = 26'h2AA; i_pi_data = 32'hCAFE_F00D;
        step();
        i_pi_request = 1'b0; i_mem_busy = 1'b0;
        step();
        #1;
        total++; if ({o_mem_request, o_mem_write} !== 2'b01) begin bad++; $display("FAIL midrst_wait got req=%b wr=%b need 0/1", o_mem_request, o_mem_write); end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        #1;
        total++; if ({o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data} !== 64'd0) begin bad++; $display("FAIL midrst_fields got %b%b/%h/%h/%h need 0", o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data); end
        i_mem_ack = 1'b1; i_mem_data = 32'h99;
        #1;
        total++; if ({o_pi_ack, o_cpu_ack} !== 2'b00) begin bad++; $display("FAIL midrst_late_ack got %b need 00", {o_pi_ack, o_cpu_ack}); end
        step();
        i_mem_ack = 1'b0;
        i_pi_request = 1'b1; i_pi_write = 1'b0; i_pi_bank = 4'd1; i_pi_address = 26'h8;
        #1;
        total++; if (o_pi_busy !== 1'b0) begin bad++; $display("FAIL midrst_next_busy got %b need 0", o_pi_busy); end
        step();
        i_pi_request = 1'b0;
        #1;
        total++; if ({o_mem_request, o_mem_address} !== {1'b1, 26'h8}) begin bad++; $display("FAIL midrst_next_issue got %b/%h need 1/0000008", o_mem_request, o_mem_address); end
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0000_1234;
        #1;
        total++; if ({o_pi_ack, o_pi_data} !== {1'b1, 32'h0000_1234}) begin bad++; $display("FAIL midrst_next_ack got %b/%h need 1/00001234", o_pi_ack, o_pi_data); end
        step();
        i_mem_ack = 1'b0;
        $display("txn reset mid-transaction: recovered");
    endtask

    task automatic test_back_to_back();
        i_cpu_request = 1'b1; i_cpu_write = 1'b1; i_cpu_bank = 4'd2; i_cpu_address = 26'h3FFFFFC; i_cpu_data = 32'h1234_5678;
        #1;
        total++; if (o_cpu_busy !== 1'b0) begin bad++; $display("FAIL b2b_cpu_accept got %b need 0", o_cpu_busy); end
        step();
        i_cpu_request = 1'b0;
        i_pi_request = 1'b1; i_pi_write = 1'b0; i_pi_bank = 4'd1; i_pi_address = 26'h30;
        i_mem_busy = 1'b1;
        #1;
        total++; if ({o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data} !== {1'b1, 1'b1, 4'd2, 26'h3FFFFFC, 32'h1234_5678}) begin
            bad++; $display("FAIL b2b_fields got %b%b/%h/%h/%h need 11/2/3fffffc/12345678", o_mem_request, o_mem_write, o_mem_bank, o_mem_address, o_mem_data);
        end
        total++; if (o_pi_busy !== 1'b1) begin bad++; $display("FAIL b2b_pi_busy_issue got %b need 1", o_pi_busy); end
        step();
        i_mem_busy = 1'b0;
        #1;
        total++; if (o_pi_busy !== 1'b1) begin bad++; $display("FAIL b2b_pi_busy_issue2 got %b need 1", o_pi_busy); end
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0;
        #1;
        total++; if ({o_cpu_ack, o_pi_ack, o_pi_busy} !== 3'b101) begin bad++; $display("FAIL b2b_cpu_ack got cpu=%b pi=%b busy=%b need 1/0/1", o_cpu_ack, o_pi_ack, o_pi_busy); end
        step();
        i_mem_ack = 1'b0;
        #1;
        total++; if (o_pi_busy !== 1'b0) begin bad++; $display("FAIL b2b_pi_accept got %b need 0", o_pi_busy); end
        step();
        i_pi_request = 1'b0;
        #1;
        total++; if ({o_mem_write, o_mem_address} !== {1'b0, 26'h30}) begin bad++; $display("FAIL b2b_pi_fields got %b/%h need 0/0000030", o_mem_write, o_mem_address); end
        step();
        i_mem_ack = 1'b1; i_mem_data = 32'h0000_0005;
        #1;
        total++; if ({o_pi_ack, o_pi_data, o_cpu_ack} !== {1'b1, 32'h0000_0005, 1'b0}) begin bad++; $display("FAIL b2b_pi_ack got %b/%h/%b need 1/00000005/0", o_pi_ack, o_pi_data, o_cpu_ack); end
        step();
        i_mem_ack = 1'b0;
        $display("txn cpu_write bank2 addr 3fffffc then pi read: done");
    endtask

    initial begin
        test_reset();
        test_pi_read();
        test_simultaneous();
        test_bank0_write();
        test_stray_ack();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
